// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam int REG_AW      = 5;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: data-cache wait FSM with watchdog,
// load-use bubble insertion, taken-branch flush and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              idex_memRead_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_write_o,
    output logic              ifid_stall_o,
    output logic              idex_stall_o,
    output logic              exmem_stall_o,
    output logic              memwb_stall_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              wd_error_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  hazard_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          wd_err;

    logic load_use, miss;
    logic full_stall, lu_act, br_act;

    assign load_use = idex_memRead_i && (idex_rt_i != '0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    assign miss     = mem_req_i && !mem_ack_i;

    // Memory stall outranks load-use, which outranks branch flush.
    always_comb begin
        state_nxt  = state;
        full_stall = 1'b0;
        lu_act     = 1'b0;
        br_act     = 1'b0;
        case (state)
            RUN: begin
                if (miss) begin
                    full_stall = 1'b1;
                    state_nxt  = MEM_WAIT;
                end else if (load_use) begin
                    lu_act = 1'b1;
                end else if (branch_taken_i) begin
                    br_act = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt = RUN;
                end else begin
                    full_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST)
                        state_nxt = ERROR;
                end
            end
            ERROR: full_stall = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    // Reset forces a safe pipeline: no PC update, NOPs into IF/ID and ID/EX.
    assign pc_write_o    = rst_i & ~full_stall & ~lu_act;
    assign ifid_stall_o  = rst_i & (full_stall | lu_act);
    assign idex_stall_o  = rst_i & full_stall;
    assign exmem_stall_o = rst_i & full_stall;
    assign memwb_stall_o = rst_i & full_stall;
    assign ifid_flush_o  = ~rst_i | br_act;
    assign idex_bubble_o = ~rst_i | lu_act;
    assign wd_error_o    = wd_err;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
            wd_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            wd_err <= wd_err | (state_nxt == ERROR);
            // Cleared while in RUN so every MEM_WAIT entry starts a fresh window.
            if (state == RUN)
                wait_cnt <= '0;
            else if (state == MEM_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk_i),
        .clear_n (rst_i),
        .inc     (full_stall),
        .count   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk     (clk_i),
        .clear_n (rst_i),
        .inc     (lu_act),
        .count   (hazard_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk_i),
        .clear_n (rst_i),
        .inc     (br_act),
        .count   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;
    localparam int CW = 4;

    // {pc_write, ifid_stall, idex_stall, exmem_stall, memwb_stall, flush, bubble, wd_error}
    localparam logic [7:0] C_RST  = 8'b0_0000_11_0;
    localparam logic [7:0] C_RSTE = 8'b0_0000_11_1;
    localparam logic [7:0] C_IDLE = 8'b1_0000_00_0;
    localparam logic [7:0] C_FULL = 8'b0_1111_00_0;
    localparam logic [7:0] C_LU   = 8'b0_1000_01_0;
    localparam logic [7:0] C_BR   = 8'b1_0000_10_0;
    localparam logic [7:0] C_ERR  = 8'b0_1111_00_1;

    typedef struct {
        string       nm;
        logic [7:0]  ctl;
        bit          chk;
        logic [CW-1:0] sc, hc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic memrd = 1'b0, br = 1'b0, rq = 1'b0, ak = 1'b0;
    logic [4:0] xrt = '0, rs = '0, rt = '0;
    logic pc_write, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic ifid_flush, idex_bubble, wd_error;
    logic [CW-1:0] stall_cnt, hazard_cnt, flush_cnt;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_memRead_i (memrd),
        .idex_rt_i      (xrt),
        .ifid_rs_i      (rs),
        .ifid_rt_i      (rt),
        .branch_taken_i (br),
        .mem_req_i      (rq),
        .mem_ack_i      (ak),
        .pc_write_o     (pc_write),
        .ifid_stall_o   (ifid_stall),
        .idex_stall_o   (idex_stall),
        .exmem_stall_o  (exmem_stall),
        .memwb_stall_o  (memwb_stall),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .wd_error_o     (wd_error),
        .stall_cnt_o    (stall_cnt),
        .hazard_cnt_o   (hazard_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    // Monitor: one vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = q.pop_front();
            act = {pc_write, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                   ifid_flush, idex_bubble, wd_error};
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
            end
            if (e.chk) begin
                tests++;
                if ({stall_cnt, hazard_cnt, flush_cnt} !== {e.sc, e.hc, e.fc}) begin
                    fails++;
                    $display("FAIL %s cnt: got s=%0d h=%0d f=%0d want s=%0d h=%0d f=%0d",
                             e.nm, stall_cnt, hazard_cnt, flush_cnt, e.sc, e.hc, e.fc);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic lr,
                       input logic [4:0] x, input logic [4:0] s, input logic [4:0] t,
                       input logic b, input logic req, input logic ack,
                       input logic [7:0] ctl, input bit chk = 1'b0,
                       input int sc = 0, input int hc = 0, input int fc = 0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; memrd = lr; xrt = x; rs = s; rt = t; br = b; rq = req; ak = ack;
        e.nm = nm; e.ctl = ctl; e.chk = chk;
        e.sc = CW'(sc); e.hc = CW'(hc); e.fc = CW'(fc);
        q.push_back(e);
    endtask

    initial begin
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 1, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 1, 0, 0, 0);
        cyc("idle", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0, 0, 0);
        cyc("lu_rs", 1, 1, 8, 8, 0, 0, 0, 0, C_LU, 1, 0, 0, 0);
        cyc("post_lu", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0, 1, 0);
        cyc("lu_r0", 1, 1, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0, 1, 0);
        cyc("lu_rt", 1, 1, 9, 3, 9, 0, 0, 0, C_LU);
        cyc("no_load", 1, 0, 9, 9, 0, 0, 0, 0, C_IDLE, 1, 0, 2, 0);
        // miss: entry + 5 wait cycles, then ack
        cyc("miss_in", 1, 0, 0, 0, 0, 0, 1, 0, C_FULL, 1, 0, 2, 0);
        for (int i = 0; i < 5; i++)
            cyc("miss_wait", 1, (i == 2), 8, 8, 0, (i == 1), 1, 0, C_FULL);
        cyc("miss_ack", 1, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 1, 6, 2, 0);
        cyc("hit", 1, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 1, 6, 2, 0);
        cyc("br_lu", 1, 1, 8, 8, 0, 1, 0, 0, C_LU, 1, 6, 2, 0);
        cyc("br", 1, 0, 8, 8, 0, 1, 0, 0, C_BR, 1, 6, 3, 0);
        cyc("post_br", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 6, 3, 1);
        cyc("miss2_in", 1, 0, 0, 0, 0, 0, 1, 0, C_FULL, 1, 6, 3, 1);
        cyc("ack_lu", 1, 1, 5, 5, 0, 0, 1, 1, C_IDLE, 1, 7, 3, 1);
        cyc("lu_after", 1, 1, 5, 5, 0, 0, 0, 0, C_LU, 1, 7, 3, 1);
        cyc("idle2", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 7, 4, 1);
        // watchdog: entry + TO wait cycles, then ERROR
        cyc("to_in", 1, 0, 0, 0, 0, 0, 1, 0, C_FULL, 1, 7, 4, 1);
        for (int i = 0; i < TO; i++)
            cyc("to_wait", 1, 0, 0, 0, 0, 0, 1, 0, C_FULL, 1, (8 + i > 15) ? 15 : 8 + i, 4, 1);
        cyc("err", 1, 0, 0, 0, 0, 0, 1, 0, C_ERR, 1, 15, 4, 1);
        cyc("err_ack", 1, 1, 8, 8, 0, 1, 1, 1, C_ERR, 1, 15, 4, 1);
        cyc("err_rst", 0, 0, 0, 0, 0, 0, 0, 0, C_RSTE, 1, 15, 4, 1);
        cyc("rst_clr", 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 1, 0, 0, 0);
        cyc("idle3", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc("lu_sat", 1, 1, 8, 8, 0, 0, 0, 0, C_LU);
        cyc("sat_chk", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0, 15, 0);
        // back-to-back misses, each acked on its last allowed wait cycle
        for (int m = 0; m < 2; m++) begin
            cyc("b2b_in", 1, 0, 0, 0, 0, 0, 1, 0, C_FULL);
            for (int i = 0; i < TO - 1; i++)
                cyc("b2b_wait", 1, 0, 0, 0, 0, 0, 1, 0, C_FULL);
            cyc("b2b_ack", 1, 0, 0, 0, 0, 0, 1, 1, C_IDLE);
        end
        cyc("final", 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 15, 15, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It generates the PC write enable, per-register stall and flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB, and the bubble insert. It sequences three events: multi-cycle data-cache accesses through a wait FSM with a watchdog, load-use hazards and taken-branch flushes. It also keeps saturating performance counters, which are readable by the debug path.

## Interface
- TIMEOUT, 64, max MEM_WAIT cycles before the watchdog trips (≥2)
- CNT_W, 16, width of each performance counter
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-low reset
- idex_memRead_i  in  1  ID/EX holds a load
- idex_rt_i  in  5  load destination in ID/EX
- ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in ID
- branch_taken_i  in  1  branch/jump resolved taken in ID
- mem_req_i  in  1  EX/MEM instruction reads or writes data memory
- mem_ack_i  in  1  data cache: access completes this cycle
- pc_write_o  out  1  PC update enable
- ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o  out  1 each  hold register
- ifid_flush_o  out  1  load NOP into IF/ID
- idex_bubble_o  out  1  zero control fields entering ID/EX
- wd_error_o  out  1  sticky watchdog error
- stall_cnt_o, hazard_cnt_o, flush_cnt_o  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- RUN:
  - If mem_req_i=1 and mem_ack_i=0, go to MEM_WAIT. The full-stall outputs are asserted in this same cycle (Mealy).
  - Otherwise evaluate hazards.
- MEM_WAIT:
  - Full stall: pc_write_o=0 and all four stall outputs are 1. Flush and bubble are 0. Load-use and branch are ignored.
  - When mem_ack_i=1: stall deasserts in that same cycle, so all registers capture. Go to RUN.
  - The wait counter increments each MEM_WAIT cycle. If it reaches TIMEOUT-1 without an ack, go to ERROR.
- ERROR: full stall is held and wd_error_o=1 until reset.
- Load-use:
  - Condition: idex_memRead_i=1, idex_rt_i≠0, and idex_rt_i equals ifid_rs_i or ifid_rt_i.
  - Response: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. EX/MEM and MEM/WB advance.
- Branch: when branch_taken_i=1 with no load-use, ifid_flush_o=1 and pc_write_o=1.
- Priority: memory stall, then load-use, then branch. A branch that coincides with load-use is not flushed; it re-evaluates next cycle with the operand available.
- Idle (RUN, no event): pc_write_o=1 and every other control output is 0.
- Counters:
  - stall_cnt_o increments on every cycle with the full stall asserted (including ERROR).
  - hazard_cnt_o increments per load-use bubble.
  - flush_cnt_o increments per IF/ID flush.
  - All three saturate at 2^CNT_W-1; they do not wrap.

## Timing
- While rst_i=0: pc_write_o=0, all stalls=0, ifid_flush_o=1, idex_bubble_o=1.
- On the first edge with rst_i=0: state=RUN, wait counter=0, wd_error_o=0, all perf counters=0.
- Control outputs are combinational from inputs and state, with zero latency. State and counters update on the edge.
- A cache hit (mem_ack_i=1 on the request cycle) causes no stall and does not leave RUN.
- A miss of N wait cycles followed by ack holds MEM_WAIT for N cycles. stall_cnt_o grows by N+1, which counts the entry cycle.
- The wait counter clears on every entry to MEM_WAIT. Back-to-back misses each get a full TIMEOUT.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN at the next edge and clears the error.
- Simultaneous mem_ack_i and a new load-use in the RUN cycle after the ack are evaluated normally.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR)
  - register address width 5
  - the default TIMEOUT and CNT_W constants
- One sub-module: sat_counter (parameter W, synchronous active-low clear, inc enable, saturating). It is instantiated three times for the perf counters. The watchdog counter is local.

## Test plan
- Reset → pc_write_o=0, ifid_flush_o=1, counters=0. Release → idle outputs, pc_write_o=1.
- Load-use: idex_memRead_i=1, idex_rt_i=8, ifid_rs_i=8 for one cycle → pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, hazard_cnt_o=1. Repeat with idex_rt_i=0 → no stall.
- Miss: mem_req_i=1 with ack delayed 5 cycles → all stalls=1 for 5 cycles, release on the ack cycle, stall_cnt_o=6, state RUN.
- Timeout with TIMEOUT=8: mem_req_i=1 and no ack → ERROR after 8 stall cycles, wd_error_o=1 held; rst_i=0 clears it.
- Priority: branch_taken_i=1 together with load-use → no flush, bubble inserted. Next cycle with the hazard gone → ifid_flush_o=1, flush_cnt_o=1. Branch during MEM_WAIT → ignored.
- Saturation with CNT_W=4: 20 load-use events → hazard_cnt_o=15.
